// File: rtl/fwd_pkg.sv
// Shared types for the decode-stage forwarding / hazard unit.
//   ridx_t      register tag; MSB selects FPR(1)/GPR(0), low bits are the index
//   fwd_tag_t   one in-flight destination-write entry of the tag pipeline
//   FWD_FPR_BIT position of the register-file select bit inside a tag
package fwd_pkg;

   localparam int FWD_RIDX_W  = 6;
   localparam int FWD_FPR_BIT = FWD_RIDX_W - 1;

   typedef logic [FWD_RIDX_W-1:0] ridx_t;

   typedef struct packed {
      logic  valid;
      logic  wen;
      logic  is_load;
      ridx_t dst;
   } fwd_tag_t;

endpackage

// File: rtl/fwd_src_select.sv
// Per-source producer selection.
// Scans the tag pipeline from the youngest stage (0) to the oldest and takes
// the first entry that writes the requested tag. A load winner that has not
// yet reached LOAD_RDY_STAGE reports a hazard instead of a hit.
// Ports:
//   entries   in   tag pipeline, entry k = stage k
//   src       in   source register tag (full compare, GPR/FPR never alias)
//   src_use   in   the operand is actually read
//   stage_val in   result value held in each stage, stage k at [k*DATA_W +: DATA_W]
//   hit       out  operand taken from a stage
//   val       out  forwarded value (0 when no hit)
//   hazard    out  youngest producer is a load whose data is not yet valid
module fwd_src_select
   import fwd_pkg::*;
#(
   parameter int LD             = 3,
   parameter int DATA_W         = 64,
   parameter int LOAD_RDY_STAGE = 2
) (
   input  fwd_tag_t [LD-1:0]        entries,
   input  ridx_t                    src,
   input  logic                     src_use,
   input  logic [LD*DATA_W-1:0]     stage_val,
   output logic                     hit,
   output logic [DATA_W-1:0]        val,
   output logic                     hazard
);

   logic found;

   always_comb begin
      hit    = 1'b0;
      val    = '0;
      hazard = 1'b0;
      found  = 1'b0;
      for (int k = 0; k < LD; k++) begin
         if (!found && src_use && entries[k].valid && entries[k].wen &&
             (entries[k].dst == src)) begin
            found = 1'b1;
            if (entries[k].is_load && (k < LOAD_RDY_STAGE)) begin
               hazard = 1'b1;
            end else begin
               hit = 1'b1;
               val = stage_val[k*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Decode-stage forwarding control with its own in-flight destination tag
// pipeline. For each source operand it selects the youngest matching producer,
// forwards that stage's value, and stalls decode on a load-use hazard.
// Optional feature: define FWD_STALL_CNT_EN to add a saturating 32-bit
// stall_cnt output counting stalled cycles (cleared by rst).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   dec_valid      decode slot holds an instruction
//   dec_wen        decoded instruction writes dec_wdst
//   dec_wdst       destination tag
//   dec_is_load    decoded instruction is a load
//   dec_src_use    per-source operand read flag
//   dec_src        source tags, source j at [j*RIDX_W +: RIDX_W]
//   stage_val      result value in each post-decode stage
//   flush          kill all in-flight entries
//   stall          hold decode this cycle
//   issue          decode instruction enters stage 0 this cycle
//   fwd_hit        source j is forwarded from a stage
//   fwd_val        forwarded value, source j at [j*DATA_W +: DATA_W]
//   stall_cnt      (FWD_STALL_CNT_EN only) stalled-cycle count
module fwd_hazard_unit
   import fwd_pkg::*;
#(
   parameter int LD             = 3,
   parameter int NSRC           = 3,
   parameter int RIDX_W         = FWD_RIDX_W,
   parameter int DATA_W         = 64,
   parameter int LOAD_RDY_STAGE = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     dec_valid,
   input  logic                     dec_wen,
   input  logic [RIDX_W-1:0]        dec_wdst,
   input  logic                     dec_is_load,
   input  logic [NSRC-1:0]          dec_src_use,
   input  logic [NSRC*RIDX_W-1:0]   dec_src,
   input  logic [LD*DATA_W-1:0]     stage_val,
   input  logic                     flush,
   output logic                     stall,
   output logic                     issue,
   output logic [NSRC-1:0]          fwd_hit,
   output logic [NSRC*DATA_W-1:0]   fwd_val
`ifdef FWD_STALL_CNT_EN
   ,
   output logic [31:0]              stall_cnt
`endif
);

   if (LOAD_RDY_STAGE >= LD) begin : g_bad_rdy
      $error("fwd_hazard_unit: LOAD_RDY_STAGE must be below LD");
   end
   if (RIDX_W != FWD_RIDX_W) begin : g_bad_ridx
      $error("fwd_hazard_unit: RIDX_W must match fwd_pkg::FWD_RIDX_W");
   end

   fwd_tag_t [LD-1:0] entries;
   fwd_tag_t          dec_tag;
   logic [NSRC-1:0]   hazard;

   always_comb begin
      dec_tag         = '0;
      dec_tag.valid   = 1'b1;
      dec_tag.wen     = dec_wen;
      dec_tag.is_load = dec_is_load;
      dec_tag.dst     = dec_wdst;
   end

   for (genvar j = 0; j < NSRC; j++) begin : g_src
      logic              hit_j;
      logic [DATA_W-1:0] val_j;

      fwd_src_select #(
         .LD             (LD),
         .DATA_W         (DATA_W),
         .LOAD_RDY_STAGE (LOAD_RDY_STAGE)
      ) u_sel (
         .entries   (entries),
         .src       (dec_src[j*RIDX_W +: RIDX_W]),
         .src_use   (dec_src_use[j]),
         .stage_val (stage_val),
         .hit       (hit_j),
         .val       (val_j),
         .hazard    (hazard[j])
      );

      // Reset forces every output low; flush still lets forwarding compute.
      assign fwd_hit[j]                    = hit_j & ~rst;
      assign fwd_val[j*DATA_W +: DATA_W]   = rst ? '0 : val_j;
   end

   assign stall = dec_valid & (|hazard) & ~flush & ~rst;
   assign issue = dec_valid & ~stall & ~flush & ~rst;

   // A stalled instruction inserts a bubble while older entries keep moving,
   // so a load-use stall releases on its own.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         entries <= '0;
      end else begin
         for (int k = LD-1; k > 0; k--) begin
            entries[k] <= entries[k-1];
         end
         entries[0] <= issue ? dec_tag : '0;
      end
   end

`ifdef FWD_STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

   logic          clk = 1'b0;
   logic          rst;
   logic          dec_valid, dec_wen, dec_is_load, flush;
   logic [5:0]    dec_wdst;
   logic [2:0]    dec_src_use;
   logic [5:0]    s0, s1, s2;
   logic [17:0]   dec_src;
   logic [63:0]   sv0, sv1, sv2;
   logic [191:0]  stage_val;
   logic          stall, issue;
   logic [2:0]    fwd_hit;
   logic [191:0]  fwd_val;
`ifdef FWD_STALL_CNT_EN
   logic [31:0]   stall_cnt;
`endif

   assign dec_src   = {s2, s1, s0};
   assign stage_val = {sv2, sv1, sv0};

   always #5 clk = ~clk;

   fwd_hazard_unit dut (
      .clk         (clk),
      .rst         (rst),
      .dec_valid   (dec_valid),
      .dec_wen     (dec_wen),
      .dec_wdst    (dec_wdst),
      .dec_is_load (dec_is_load),
      .dec_src_use (dec_src_use),
      .dec_src     (dec_src),
      .stage_val   (stage_val),
      .flush       (flush),
      .stall       (stall),
      .issue       (issue),
      .fwd_hit     (fwd_hit),
      .fwd_val     (fwd_val)
`ifdef FWD_STALL_CNT_EN
      ,
      .stall_cnt   (stall_cnt)
`endif
   );

   typedef struct {
      string        nm;
      logic         st;
      logic         is;
      logic [2:0]   h;
      logic [191:0] v;
      logic [31:0]  c;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] cnt_model = 0;

   // Monitor: one expected record per driven cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         if (stall !== e.st) begin
            errors++;
            $display("FAIL %s stall got %0b exp %0b", e.nm, stall, e.st);
         end
         checks++;
         if (issue !== e.is) begin
            errors++;
            $display("FAIL %s issue got %0b exp %0b", e.nm, issue, e.is);
         end
         checks++;
         if (fwd_hit !== e.h) begin
            errors++;
            $display("FAIL %s fwd_hit got %b exp %b", e.nm, fwd_hit, e.h);
         end
         checks++;
         if (fwd_val !== e.v) begin
            errors++;
            $display("FAIL %s fwd_val got %h exp %h", e.nm, fwd_val, e.v);
         end
`ifdef FWD_STALL_CNT_EN
         checks++;
         if (stall_cnt !== e.c) begin
            errors++;
            $display("FAIL %s stall_cnt got %0d exp %0d", e.nm, stall_cnt, e.c);
         end
`endif
      end
   end

   task automatic cyc(input string nm,
                      input logic i_dv, input logic i_wen, input logic i_ld,
                      input logic [5:0] i_wdst, input logic [2:0] i_use,
                      input logic [5:0] i_s0, input logic [5:0] i_s1, input logic [5:0] i_s2,
                      input logic i_fl, input logic i_rst,
                      input logic e_st, input logic e_is, input logic [2:0] e_h,
                      input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
      exp_t e;
      @(posedge clk);
      #1;
      dec_valid   = i_dv;
      dec_wen     = i_wen;
      dec_is_load = i_ld;
      dec_wdst    = i_wdst;
      dec_src_use = i_use;
      s0 = i_s0; s1 = i_s1; s2 = i_s2;
      flush = i_fl;
      rst   = i_rst;
      e.nm = nm; e.st = e_st; e.is = e_is; e.h = e_h;
      e.v  = {e2, e1, e0};
      e.c  = cnt_model;
      sb.push_back(e);
      if (i_rst) cnt_model = 0;
      else if (e_st) cnt_model = cnt_model + 1;
   endtask

   initial begin
      rst = 1'b1; dec_valid = 0; dec_wen = 0; dec_is_load = 0; dec_wdst = 0;
      dec_src_use = 0; s0 = 0; s1 = 0; s2 = 0; flush = 0;
      sv0 = 64'h0; sv1 = 64'h0; sv2 = 64'h0;
      repeat (2) @(posedge clk);

      //   name            dv wen ld wdst   use     s0     s1     s2   fl rst  st is hit     v0        v1        v2
      cyc("rst_hold",     1, 1, 0, 6'h03, 3'b111, 6'h00, 6'h00, 6'h00, 0, 1,  0, 0, 3'b000, 0, 0, 0);
      cyc("post_rst",     1, 0, 0, 6'h00, 3'b111, 6'h00, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      cyc("alu_issue",    1, 1, 0, 6'h03, 3'b000, 6'h00, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      sv0 = 64'hAA;
      cyc("alu_fwd",      1, 0, 0, 6'h00, 3'b001, 6'h03, 6'h00, 6'h00, 0, 0,  0, 1, 3'b001, 64'hAA, 0, 0);
      cyc("young_p2",     1, 1, 0, 6'h05, 3'b000, 6'h00, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      cyc("young_gap",    0, 0, 0, 6'h00, 3'b000, 6'h00, 6'h00, 6'h00, 0, 0,  0, 0, 3'b000, 0, 0, 0);
      cyc("young_p0",     1, 1, 0, 6'h05, 3'b000, 6'h00, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      sv0 = 64'h22; sv1 = 64'h77; sv2 = 64'h11;
      cyc("young_win",    1, 0, 0, 6'h00, 3'b101, 6'h05, 6'h00, 6'h05, 0, 0,  0, 1, 3'b101, 64'h22, 0, 64'h22);
      sv1 = 64'h33;
      cyc("stage1_fwd",   0, 0, 0, 6'h00, 3'b001, 6'h05, 6'h00, 6'h00, 0, 0,  0, 0, 3'b001, 64'h33, 0, 0);
      cyc("load_issue",   1, 1, 1, 6'h07, 3'b000, 6'h00, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      sv0 = 64'hDEAD; sv1 = 64'hBEEF; sv2 = 64'h0;
      cyc("load_use0",    1, 0, 0, 6'h00, 3'b010, 6'h00, 6'h07, 6'h00, 0, 0,  1, 0, 3'b000, 0, 0, 0);
      cyc("load_use1",    1, 0, 0, 6'h00, 3'b010, 6'h00, 6'h07, 6'h00, 0, 0,  1, 0, 3'b000, 0, 0, 0);
      sv2 = 64'h1234;
      cyc("load_ready",   1, 0, 0, 6'h00, 3'b010, 6'h00, 6'h07, 6'h00, 0, 0,  0, 1, 3'b010, 0, 64'h1234, 0);
      cyc("alias_p",      1, 1, 0, 6'h23, 3'b000, 6'h00, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      sv0 = 64'h55;
      cyc("alias_chk",    1, 0, 0, 6'h00, 3'b101, 6'h03, 6'h23, 6'h23, 0, 0,  0, 1, 3'b100, 0, 0, 64'h55);
      cyc("flush_ld",     1, 1, 1, 6'h09, 3'b000, 6'h00, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      sv0 = 64'h1; sv1 = 64'h2; sv2 = 64'h3;
      cyc("flush_stall",  1, 0, 0, 6'h00, 3'b001, 6'h09, 6'h00, 6'h00, 0, 0,  1, 0, 3'b000, 0, 0, 0);
      cyc("flush_cyc",    1, 0, 0, 6'h00, 3'b001, 6'h09, 6'h00, 6'h00, 1, 0,  0, 0, 3'b000, 0, 0, 0);
      cyc("flush_after",  1, 0, 0, 6'h00, 3'b001, 6'h09, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      cyc("rst_ld",       1, 1, 1, 6'h0A, 3'b000, 6'h00, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);
      cyc("rst_stall",    1, 0, 0, 6'h00, 3'b001, 6'h0A, 6'h00, 6'h00, 0, 0,  1, 0, 3'b000, 0, 0, 0);
      cyc("rst_mid",      1, 0, 0, 6'h00, 3'b001, 6'h0A, 6'h00, 6'h00, 0, 1,  0, 0, 3'b000, 0, 0, 0);
      cyc("rst_after",    1, 0, 0, 6'h00, 3'b001, 6'h0A, 6'h00, 6'h00, 0, 0,  0, 1, 3'b000, 0, 0, 0);

      @(negedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain pending records got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Successor to the decode-stage forwarding control, parametrised in source count, post-decode depth, register-index width and data width.
- Keeps its own registered tag pipeline of in-flight destination writes; the caller no longer supplies post-decode instructions.
- Per source operand: picks the youngest matching producer, muxes its value, and raises a load-use stall when that producer's data is not yet valid.
- Sits between decode and the register-read/execute boundary.

Parameters:
- LD, 3: post-decode stages tracked (stage 0 = youngest).
- NSRC, 3: source operands per decoded instruction.
- RIDX_W, 6: register tag width; MSB selects FPR(1)/GPR(0), low bits are the index.
- DATA_W, 64: forwarded value width.
- LOAD_RDY_STAGE, 2: first stage index at which a load's result is valid in stage_val; range 0..LD-1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- dec_valid  in  1  decode slot holds an instruction
- dec_wen  in  1  decoded instruction writes dec_wdst
- dec_wdst  in  RIDX_W  destination tag
- dec_is_load  in  1  decoded instruction is a load
- dec_src_use  in  NSRC  per-source "operand read" flag
- dec_src  in  NSRC*RIDX_W  source tags, source j at [j*RIDX_W +: RIDX_W]
- stage_val  in  LD*DATA_W  result value currently held in each stage
- flush  in  1  kill all in-flight entries
- stall  out  1  hold decode this cycle
- issue  out  1  decode instruction accepted into stage 0 this cycle
- fwd_hit  out  NSRC  source j is taken from a stage
- fwd_val  out  NSRC*DATA_W  forwarded value, source j at [j*DATA_W +: DATA_W]

Behaviour:
- State: LD tag entries {valid, wen, is_load, dst}, registered.
- Shift each cycle: entry k+1 <= entry k.
- Entry 0 <= decode tag when issue is 1; otherwise entry 0 <= bubble (valid=0).
- issue = dec_valid & ~stall & ~flush & ~rst.
- A stalled instruction is not advanced; downstream entries still advance.
- Match for source j at stage k: dec_src_use[j] & valid_k & wen_k & (dst_k == src_j). Full RIDX_W compare, so GPR and FPR are never aliased.
- Priority: lowest k wins (youngest producer).
- Winning stage k with is_load=1 and k < LOAD_RDY_STAGE is a load-use hazard:
  - fwd_hit[j]=0, fwd_val[j]=0.
  - stall=1 if dec_valid.
- Otherwise a winner gives fwd_hit[j]=1 and fwd_val[j]=stage_val[k].
- No match: fwd_hit[j]=0, fwd_val[j]=0.
- stall = OR of all source hazards, gated by dec_valid.
- Outputs are combinational from entries plus dec inputs (zero-cycle latency). A newly issued producer becomes matchable the next cycle at stage 0. A producer is forgotten after leaving stage LD-1.
- flush:
  - Next cycle all entries are invalid.
  - In the flush cycle, stall=0, issue=0, and fwd_* are still computed.
  - Flush takes priority over a simultaneous issue.
- rst:
  - While rst=1, all outputs are forced to 0.
  - Next cycle all entries are invalid.
  - After reset: stall=0, issue=0, fwd_hit=0, fwd_val=0.
  - Reset mid-stall: the stall drops immediately.
- Stall self-releases: the load advances each cycle, so stall lasts at most LOAD_RDY_STAGE - k cycles.
- Constraint: elaboration error if LOAD_RDY_STAGE >= LD.

Optional Feature:
- FWD_STALL_CNT_EN defined:
  - Adds output stall_cnt, 32 bits.
  - Increments on each cycle where stall=1 and rst=0; saturates at 0xFFFF_FFFF.
  - Synchronously cleared to 0 by rst.
- Undefined: no port and no counter logic.

Decomposition:
- Shared package fwd_pkg:
  - typedef ridx_t (RIDX_W bits).
  - struct fwd_tag_t {valid, wen, is_load, dst}.
  - Constant FWD_FPR_BIT = RIDX_W-1.
- Sub-module fwd_src_select, instantiated NSRC times via generate:
  - Inputs: entries, one source tag, use flag, stage_val.
  - Outputs: hit, val, hazard.
- Tag pipeline and stall/issue logic stay in fwd_hazard_unit.

Test Plan:
- ALU chain: issue wdst=0x03 (non-load); next cycle decode src0=0x03, stage_val[0]=0xAA -> fwd_hit[0]=1, fwd_val=0xAA, stall=0.
- Youngest wins: producers for 0x05 at stage 2 (val 0x11) and stage 0 (val 0x22) -> fwd_val=0x22.
- Load-use: issue load wdst=0x07; next cycle src1=0x07 -> stall=1 for 2 cycles, issue=0. Third cycle: load at stage 2, stage_val[2]=0x1234 -> fwd_hit[1]=1, val 0x1234, issue=1.
- Aliasing: producer wdst=0x23 (FPR 3); source 0x03 -> fwd_hit=0. dec_src_use=0 on a matching tag -> fwd_hit=0.
- Flush: flush while load-use stall with dec_valid=1 -> stall=0, issue=0. Next cycle same src -> no hit. Reset asserted mid-stall -> all outputs 0 that cycle and entries empty after.
- FWD_STALL_CNT_EN: a 2-cycle load-use stall, then rst -> stall_cnt reads 2, then 0 after reset.
